spike_rate_decoder: RTL and testbench

- Consumes the 1-bit spike train produced by a LIF neuron and decodes it into a windowed spike-rate word plus an exponentially smoothed rate.
- Used wherever neuron outputs must become numeric commands, e.g. motor/servo setpoint logic downstream of the neuron array.
- Results leave through a one-deep valid/ready output register.

---
 rtl/spike_rate_decoder.sv | 103 ++++++++++
 tb/tb_spike_rate_decoder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_decoder.sv
// Spike-rate decoder: counts LIF spikes over a fixed window, smooths the count with a
// shift-based EMA and presents each window result through a one-deep valid/ready register.
module spike_rate_decoder #(
  parameter int WINDOW    = 100,
  parameter int CNT_W     = 8,
  parameter int EMA_SHIFT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             spike_in,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_sat,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic [CNT_W-1:0] smooth_out,
  output logic             dropped
);

  localparam int               WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIN_W-1:0]        win_cnt;
  logic [CNT_W-1:0]        spike_cnt;
  logic                    sat;
  logic                    tc;
  logic                    cnt_full;
  logic                    accepted;
  logic [CNT_W-1:0]        final_cnt;
  logic                    final_sat;
  logic signed [CNT_W:0]   diff;
  logic signed [CNT_W:0]   ema_step;
  logic signed [CNT_W+1:0] ema_sum;
  logic [CNT_W-1:0]        ema_next;

  always_comb begin
    tc        = enable && (win_cnt == WIN_LAST);
    cnt_full  = (spike_cnt == CNT_MAX);
    accepted  = rate_valid && rate_ready;
    final_cnt = spike_cnt;
    if (spike_in && !cnt_full) final_cnt = spike_cnt + CNT_ONE;
    final_sat = sat || (spike_in && cnt_full);
    // Arithmetic shift floors negative steps, so a silent input decays the EMA to exactly 0.
    diff     = $signed({1'b0, final_cnt}) - $signed({1'b0, smooth_out});
    ema_step = diff >>> EMA_SHIFT;
    ema_sum  = $signed({ema_step[CNT_W], ema_step}) + $signed({2'b00, smooth_out});
    if (ema_sum[CNT_W+1])  ema_next = '0;
    else if (ema_sum[CNT_W]) ema_next = CNT_MAX;
    else                   ema_next = ema_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_cnt   <= '0;
      spike_cnt <= '0;
      sat       <= 1'b0;
    end else if (enable) begin
      if (tc) begin
        win_cnt   <= '0;
        spike_cnt <= '0;
        sat       <= 1'b0;
      end else begin
        win_cnt <= win_cnt + WIN_ONE;
        if (spike_in) begin
          if (cnt_full) sat <= 1'b1;
          else          spike_cnt <= spike_cnt + CNT_ONE;
        end
      end
    end
  end

  // Handshake: a result transfers on any edge where rate_valid && rate_ready. While
  // rate_valid is high and rate_ready low, rate_out/rate_sat are frozen; a window ending
  // in that state is discarded and flagged on dropped for one cycle. A window ending in
  // the same cycle as an accept reloads the register and rate_valid stays high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rate_out   <= '0;
      rate_sat   <= 1'b0;
      rate_valid <= 1'b0;
      smooth_out <= '0;
      dropped    <= 1'b0;
    end else begin
      dropped <= 1'b0;
      if (tc) begin
        smooth_out <= ema_next;
        if (!rate_valid || rate_ready) begin
          rate_out   <= final_cnt;
          rate_sat   <= final_sat;
          rate_valid <= 1'b1;
        end else begin
          dropped <= 1'b1;
        end
      end else if (accepted) begin
        rate_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed testbench for spike_rate_decoder: a WINDOW=10 instance for most scenarios and a
// WINDOW=300 instance for count saturation, sharing clock, reset and inputs.
module tb_spike_rate_decoder;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       spike_in;
  logic       rate_ready;
  logic [7:0] rate_out;
  logic       rate_sat;
  logic       rate_valid;
  logic [7:0] smooth_out;
  logic       dropped;
  logic [7:0] s_rate_out;
  logic       s_rate_sat;
  logic       s_rate_valid;
  logic [7:0] s_smooth_out;
  logic       s_dropped;

  int passed = 0;
  int total  = 0;

  spike_rate_decoder #(.WINDOW(10), .CNT_W(8), .EMA_SHIFT(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .spike_in(spike_in),
    .rate_out(rate_out), .rate_sat(rate_sat), .rate_valid(rate_valid),
    .rate_ready(rate_ready), .smooth_out(smooth_out), .dropped(dropped)
  );

  spike_rate_decoder #(.WINDOW(300), .CNT_W(8), .EMA_SHIFT(2)) dut_sat (
    .clk(clk), .reset(reset), .enable(enable), .spike_in(spike_in),
    .rate_out(s_rate_out), .rate_sat(s_rate_sat), .rate_valid(s_rate_valid),
    .rate_ready(rate_ready), .smooth_out(s_smooth_out), .dropped(s_dropped)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  // Steps n cycles; mode 0: no spikes, 1: spike every cycle, 2: spike on even cycles.
  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      spike_in = (mode == 1) ? 1'b1 : (mode == 2) ? ((i % 2) == 0) : 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    int seen_valid;
    enable = 1'b1; rate_ready = 1'b0;
    apply_reset();
    run(10, 1);
    total++;
    if (rate_valid !== 1'b1) $display("FAIL reset_pre_valid got %0b want 1", rate_valid);
    else passed++;
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (rate_out !== 8'd0 || rate_valid !== 1'b0 || rate_sat !== 1'b0 ||
        smooth_out !== 8'd0 || dropped !== 1'b0)
      $display("FAIL reset_async got out=%0d valid=%0b sat=%0b smooth=%0d drop=%0b want all 0",
               rate_out, rate_valid, rate_sat, smooth_out, dropped);
    else passed++;
    #1;
    reset = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 10; i++) begin
      if (rate_valid) seen_valid++;
      run(1, 1);
    end
    total++;
    if (seen_valid !== 0) $display("FAIL reset_quiet got %0d valid cycles want 0", seen_valid);
    else passed++;
    total++;
    if (rate_valid !== 1'b1 || rate_out !== 8'd10)
      $display("FAIL reset_first_result got valid=%0b out=%0d want valid=1 out=10", rate_valid, rate_out);
    else passed++;
  endtask

  task automatic test_full_rate();
    enable = 1'b1; rate_ready = 1'b1;
    apply_reset();
    run(9, 1);
    total++;
    if (rate_valid !== 1'b0) $display("FAIL full_early_valid got %0b want 0", rate_valid);
    else passed++;
    run(1, 1);
    total++;
    if (rate_valid !== 1'b1 || rate_out !== 8'd10 || rate_sat !== 1'b0 || smooth_out !== 8'd2)
      $display("FAIL full_w1 got valid=%0b out=%0d sat=%0b smooth=%0d want 1/10/0/2",
               rate_valid, rate_out, rate_sat, smooth_out);
    else passed++;
    run(1, 1);
    total++;
    if (rate_valid !== 1'b0) $display("FAIL full_consumed got %0b want 0", rate_valid);
    else passed++;
    run(9, 1);
    total++;
    if (rate_valid !== 1'b1 || rate_out !== 8'd10 || smooth_out !== 8'd4)
      $display("FAIL full_w2 got valid=%0b out=%0d smooth=%0d want 1/10/4", rate_valid, rate_out, smooth_out);
    else passed++;
  endtask

  task automatic test_half_rate_decay();
    logic [7:0] exp_half [3];
    logic [7:0] exp_decay[3];
    exp_half  = '{8'd1, 8'd2, 8'd2};
    exp_decay = '{8'd1, 8'd0, 8'd0};
    enable = 1'b1; rate_ready = 1'b1;
    apply_reset();
    for (int w = 0; w < 3; w++) begin
      run(10, 2);
      total++;
      if (rate_valid !== 1'b1 || rate_out !== 8'd5 || smooth_out !== exp_half[w])
        $display("FAIL half_w%0d got valid=%0b out=%0d smooth=%0d want 1/5/%0d",
                 w, rate_valid, rate_out, smooth_out, exp_half[w]);
      else passed++;
    end
    for (int w = 0; w < 3; w++) begin
      run(10, 0);
      total++;
      if (rate_valid !== 1'b1 || rate_out !== 8'd0 || smooth_out !== exp_decay[w])
        $display("FAIL decay_w%0d got valid=%0b out=%0d smooth=%0d want 1/0/%0d",
                 w, rate_valid, rate_out, smooth_out, exp_decay[w]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int unstable;
    int drops;
    enable = 1'b1; rate_ready = 1'b0;
    apply_reset();
    run(10, 1);
    total++;
    if (rate_valid !== 1'b1 || rate_out !== 8'd10)
      $display("FAIL bp_w1 got valid=%0b out=%0d want 1/10", rate_valid, rate_out);
    else passed++;
    unstable = 0; drops = 0;
    for (int i = 0; i < 9; i++) begin
      run(1, 1);
      if (rate_valid !== 1'b1 || rate_out !== 8'd10 || rate_sat !== 1'b0) unstable++;
      if (dropped) drops++;
    end
    total++;
    if (unstable !== 0 || drops !== 0)
      $display("FAIL bp_hold got unstable=%0d drops=%0d want 0/0", unstable, drops);
    else passed++;
    run(1, 1);
    total++;
    if (dropped !== 1'b1 || rate_valid !== 1'b1 || rate_out !== 8'd10 || smooth_out !== 8'd4)
      $display("FAIL bp_drop got drop=%0b valid=%0b out=%0d smooth=%0d want 1/1/10/4",
               dropped, rate_valid, rate_out, smooth_out);
    else passed++;
    // third window: 5 spikes; ready rises only in the tc cycle (cycle 29)
    spike_in = 1'b1;
    @(posedge clk); #1;
    total++;
    if (dropped !== 1'b0 || rate_out !== 8'd10)
      $display("FAIL bp_drop_pulse got drop=%0b out=%0d want 0/10", dropped, rate_out);
    else passed++;
    for (int i = 1; i < 9; i++) begin
      spike_in = ((i % 2) == 0);
      @(posedge clk); #1;
    end
    spike_in = 1'b0;
    rate_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (rate_valid !== 1'b1 || rate_out !== 8'd5 || dropped !== 1'b0 || smooth_out !== 8'd4)
      $display("FAIL bp_reload got valid=%0b out=%0d drop=%0b smooth=%0d want 1/5/0/4",
               rate_valid, rate_out, dropped, smooth_out);
    else passed++;
  endtask

  task automatic test_saturation();
    enable = 1'b1; rate_ready = 1'b1;
    apply_reset();
    run(300, 1);
    total++;
    if (s_rate_valid !== 1'b1 || s_rate_out !== 8'd255 || s_rate_sat !== 1'b1 || s_smooth_out !== 8'd63)
      $display("FAIL sat_full got valid=%0b out=%0d sat=%0b smooth=%0d want 1/255/1/63",
               s_rate_valid, s_rate_out, s_rate_sat, s_smooth_out);
    else passed++;
    run(300, 0);
    total++;
    if (s_rate_valid !== 1'b1 || s_rate_out !== 8'd0 || s_rate_sat !== 1'b0 || s_smooth_out !== 8'd47)
      $display("FAIL sat_clear got valid=%0b out=%0d sat=%0b smooth=%0d want 1/0/0/47",
               s_rate_valid, s_rate_out, s_rate_sat, s_smooth_out);
    else passed++;
  endtask

  task automatic test_enable_and_reset();
    int drops;
    enable = 1'b1; rate_ready = 1'b1;
    apply_reset();
    run(4, 1);
    enable = 1'b0;
    run(5, 1);
    enable = 1'b1;
    run(5, 1);
    total++;
    if (rate_valid !== 1'b0) $display("FAIL gate_early got valid=%0b want 0", rate_valid);
    else passed++;
    run(1, 1);
    total++;
    if (rate_valid !== 1'b1 || rate_out !== 8'd10)
      $display("FAIL gate_result got valid=%0b out=%0d want 1/10", rate_valid, rate_out);
    else passed++;
    // leave this result pending, then reset at win_cnt=6 of the next window
    rate_ready = 1'b0;
    drops = 0;
    for (int i = 0; i < 6; i++) begin
      run(1, 1);
      if (dropped) drops++;
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (rate_valid !== 1'b0 || rate_out !== 8'd0 || dropped !== 1'b0)
      $display("FAIL midreset got valid=%0b out=%0d drop=%0b want 0/0/0", rate_valid, rate_out, dropped);
    else passed++;
    #1;
    reset = 1'b1;
    for (int i = 0; i < 9; i++) begin
      run(1, 1);
      if (dropped || rate_valid) drops++;
    end
    total++;
    if (drops !== 0) $display("FAIL midreset_quiet got %0d events want 0", drops);
    else passed++;
    run(1, 1);
    total++;
    if (rate_valid !== 1'b1 || rate_out !== 8'd10 || dropped !== 1'b0)
      $display("FAIL midreset_next got valid=%0b out=%0d drop=%0b want 1/10/0", rate_valid, rate_out, dropped);
    else passed++;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; spike_in = 1'b0; rate_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_full_rate();
    test_half_rate_decay();
    test_back_to_back();
    test_saturation();
    test_enable_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
